// File: rtl/apb_fifo_slave_if.sv
// APB bus and output stream bundle for apb_fifo_slave.
// The slave modport is the FIFO side; the master modport drives the bus and sinks the stream.
interface apb_fifo_slave_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PAddr;
    logic                  PSel;
    logic                  PEnable;
    logic                  PWrite;
    logic [DATA_WIDTH-1:0] PWData;
    logic [DATA_WIDTH-1:0] PRData;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output PAddr, PSel, PEnable, PWrite, PWData, out_ready,
        input  PRData, out_valid, out_data
    );

    modport slave (
        input  PAddr, PSel, PEnable, PWrite, PWData, out_ready,
        output PRData, out_valid, out_data
    );
endinterface

// File: rtl/apb_fifo_slave.sv
// Zero-wait-state APB slave feeding a FIFO that drains through a valid/ready stream.
// Optional macro APB_FIFO_IRQ_EN adds the THRESH register at 0x10 and the irq output.
module apb_fifo_slave #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic PClk,
    input  logic Rst,
`ifdef APB_FIFO_IRQ_EN
    output logic irq,
`endif
    apb_fifo_slave_if.slave bus
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [2:0] RegData   = 3'd0;
    localparam logic [2:0] RegStatus = 3'd1;
    localparam logic [2:0] RegCtrl   = 3'd2;
    localparam logic [2:0] RegErr    = 3'd3;
`ifdef APB_FIFO_IRQ_EN
    localparam logic [2:0] RegThresh = 3'd4;
    localparam logic [2:0] LastReg   = 3'd4;
`else
    localparam logic [2:0] LastReg   = 3'd3;
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic [2:0] reg_sel;
    logic       setup, access, wr_acc, rd_setup;
    logic       full, empty;
    logic       push, pop, flush, overflow, push_ok, bad_addr;

    assign reg_sel  = bus.PAddr[4:2];
    assign setup    = bus.PSel & ~bus.PEnable;
    assign access   = bus.PSel & bus.PEnable;
    assign wr_acc   = access & bus.PWrite;
    assign rd_setup = setup & ~bus.PWrite;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = wr_acc && (reg_sel == RegData);
    assign pop      = out_valid_q & bus.out_ready;
    assign flush    = wr_acc && (reg_sel == RegCtrl) && bus.PWData[0];
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign overflow = push && full && !pop;
    assign push_ok  = push && !overflow;
    assign bad_addr = access && (reg_sel > LastReg);

    logic unused_paddr;
    assign unused_paddr = ^{bus.PAddr[ADDR_WIDTH-1:5], bus.PAddr[1:0]};

`ifdef APB_FIFO_IRQ_EN
    logic [7:0] thresh_q, thresh_d;
    logic       irq_q, irq_d;

    always_comb begin
        thresh_d = thresh_q;
        if (wr_acc && (reg_sel == RegThresh)) begin
            thresh_d = bus.PWData[7:0];
        end
        irq_d = (thresh_d != 8'd0) && (32'(count_d) >= 32'(thresh_d));
    end

    always_ff @(posedge PClk or negedge Rst) begin
        if (!Rst) begin
            thresh_q <= 8'd0;
            irq_q    <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // Pointer, count and head-register next state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push_ok && pop) begin
                count_d = count_q - CntW'(1);
            end
        end
        out_valid_d = (count_d != '0);
        // The new head may be the word being written on this very edge.
        if (push_ok && (wptr_q == rptr_d)) begin
            out_data_d = bus.PWData;
        end else begin
            out_data_d = mem_q[rptr_d];
        end
    end

    // Sticky errors: set events override a same-cycle W1C.
    always_comb begin
        err_d = err_q;
        if (wr_acc && (reg_sel == RegErr)) begin
            err_d = err_q & ~bus.PWData[1:0];
        end
        err_d = err_d | {bad_addr, overflow};
    end

    // Read data is captured from pre-edge state at the end of the setup phase.
    always_comb begin
        prdata_d = prdata_q;
        if (rd_setup) begin
            prdata_d = '0;
            case (reg_sel)
                RegData: begin
                    if (out_valid_q) begin
                        prdata_d = out_data_q;
                    end
                end
                RegStatus: begin
                    prdata_d[15:8] = 8'(count_q);
                    prdata_d[1]    = full;
                    prdata_d[0]    = empty;
                end
                RegErr: begin
                    prdata_d[1:0] = err_q;
                end
`ifdef APB_FIFO_IRQ_EN
                RegThresh: begin
                    prdata_d[7:0] = thresh_q;
                end
`endif
                default: begin
                    prdata_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge PClk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= bus.PWData;
        end
    end

    always_ff @(posedge PClk or negedge Rst) begin
        if (!Rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            err_q       <= 2'b00;
            prdata_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            prdata_q    <= prdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.PRData    = prdata_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Self-checking bench for apb_fifo_slave: directed scenarios then random APB traffic,
// compared every cycle against a queue-based reference model.
module tb_apb_fifo_slave;

    localparam int DEPTH = 8;
`ifdef APB_FIFO_IRQ_EN
    localparam int LAST_OFF = 4;
`else
    localparam int LAST_OFF = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef APB_FIFO_IRQ_EN
    logic irq;
`endif

    apb_fifo_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_fifo_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .PClk(clk),
        .Rst(rst_n),
`ifdef APB_FIFO_IRQ_EN
        .irq(irq),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [1:0]  m_err = 2'b00;
    logic [31:0] m_prdata = '0;
    logic [7:0]  m_thresh = 8'd0;
    logic        m_irq = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(int off);
        logic [31:0] r = '0;
        case (off)
            0: r = (q.size() != 0) ? q[0] : 32'd0;
            1: begin
                r[15:8] = 8'(q.size());
                r[1] = (q.size() == DEPTH);
                r[0] = (q.size() == 0);
            end
            3: r[1:0] = m_err;
`ifdef APB_FIFO_IRQ_EN
            4: r[7:0] = m_thresh;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_err = 2'b00;
        m_prdata = '0;
        m_thresh = 8'd0;
        m_irq = 1'b0;
    endtask

    // Applies the model to the inputs driven now, advances one clock, then compares.
    task automatic step();
        logic setup, access, wr, popv, pushv, ovf, bad, flush;
        logic [31:0] d;
        int off;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 2) == 0);
        setup  = bus.PSel && !bus.PEnable;
        access = bus.PSel && bus.PEnable;
        wr     = bus.PWrite;
        off    = int'(bus.PAddr[4:2]);
        d      = bus.PWData;
        popv   = (q.size() != 0) && bus.out_ready;
        if (setup && !wr) m_prdata = model_read(off);
        pushv = access && wr && (off == 0);
        flush = access && wr && (off == 2) && d[0];
        ovf   = pushv && (q.size() == DEPTH) && !popv;
        bad   = access && (off > LAST_OFF);
        if (access && wr && (off == 3)) m_err = m_err & ~d[1:0];
        m_err = m_err | {bad, ovf};
`ifdef APB_FIFO_IRQ_EN
        if (access && wr && (off == 4)) m_thresh = d[7:0];
`endif
        if (flush) begin
            q.delete();
        end else begin
            if (popv) void'(q.pop_front());
            if (pushv && !ovf) q.push_back(d);
        end
        m_irq = (m_thresh != 0) && (q.size() >= int'(m_thresh));
        @(posedge clk);
        #1;
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) check("out_data", bus.out_data, q[0]);
        check("prdata", bus.PRData, m_prdata);
`ifdef APB_FIFO_IRQ_EN
        check("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    endtask

    task automatic idle(int n);
        bus.PSel = 1'b0;
        bus.PEnable = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apb_write(logic [7:0] addr, logic [31:0] data);
        bus.PAddr = addr;
        bus.PWrite = 1'b1;
        bus.PWData = data;
        bus.PSel = 1'b1;
        bus.PEnable = 1'b0;
        step();
        bus.PEnable = 1'b1;
        step();
        bus.PSel = 1'b0;
        bus.PEnable = 1'b0;
    endtask

    task automatic apb_read(logic [7:0] addr);
        bus.PAddr = addr;
        bus.PWrite = 1'b0;
        bus.PSel = 1'b1;
        bus.PEnable = 1'b0;
        step();
        bus.PEnable = 1'b1;
        step();
        bus.PSel = 1'b0;
        bus.PEnable = 1'b0;
    endtask

    initial begin
        bus.PAddr = '0;
        bus.PSel = 1'b0;
        bus.PEnable = 1'b0;
        bus.PWrite = 1'b0;
        bus.PWData = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_prdata", bus.PRData, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Reset in the middle of traffic.
        apb_write(8'h00, 32'h1);
        apb_write(8'h00, 32'h2);
        apb_write(8'h00, 32'h3);
        apb_read(8'h00);
        check("pre_rst_head", bus.PRData, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_prdata", bus.PRData, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apb_read(8'h04);
        check("status_after_rst", bus.PRData, 32'h1);

        // Fill and drain.
        for (int i = 0; i < 8; i++) apb_write(8'h00, 32'hA0 + i);
        apb_read(8'h04);
        check("status_full", bus.PRData, 32'h802);
        bus.out_ready = 1'b1;
        idle(8);
        check("drained", {31'b0, bus.out_valid}, 32'd0);

        // Overflow and W1C.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) apb_write(8'h00, 32'hB0 + i);
        apb_write(8'h00, 32'hDEAD);
        apb_read(8'h0C);
        check("err_ovf", bus.PRData, 32'h1);
        bus.out_ready = 1'b1;
        idle(8);
        check("no_9th_word", {31'b0, bus.out_valid}, 32'd0);
        apb_write(8'h0C, 32'h1);
        apb_read(8'h0C);
        check("err_cleared", bus.PRData, 32'h0);

        // Push into a full FIFO while a pop happens on the commit edge.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) apb_write(8'h00, 32'hC0 + i);
        bus.PAddr = 8'h00;
        bus.PWrite = 1'b1;
        bus.PWData = 32'hC8;
        bus.PSel = 1'b1;
        bus.PEnable = 1'b0;
        step();
        bus.PEnable = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        apb_read(8'h04);
        check("full_pop_status", bus.PRData, 32'h802);
        apb_read(8'h0C);
        check("full_pop_no_ovf", bus.PRData, 32'h0);
        bus.out_ready = 1'b1;
        idle(7);
        check("last_word", bus.out_data, 32'hC8);
        idle(1);

        // Flush and bad address.
        bus.out_ready = 1'b0;
        apb_write(8'h00, 32'h11);
        apb_write(8'h00, 32'h22);
        apb_write(8'h08, 32'h1);
        apb_read(8'h04);
        check("status_flushed", bus.PRData, 32'h1);
        apb_read(8'h00);
        check("data_empty", bus.PRData, 32'h0);
        apb_read(8'h14);
        check("bad_read", bus.PRData, 32'h0);
        apb_read(8'h0C);
        check("err_bad", bus.PRData, 32'h2);
        apb_write(8'h0C, 32'h3);

`ifdef APB_FIFO_IRQ_EN
        apb_write(8'h10, 32'h3);
        apb_write(8'h00, 32'h1);
        apb_write(8'h00, 32'h2);
        check("irq_low", {31'b0, irq}, 32'd0);
        apb_write(8'h00, 32'h3);
        check("irq_high", {31'b0, irq}, 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("irq_fall", {31'b0, irq}, 32'd0);
        apb_write(8'h08, 32'h1);
`else
        apb_read(8'h10);
        check("thresh_unmapped", bus.PRData, 32'h0);
        apb_read(8'h0C);
        check("err_0x10", bus.PRData, 32'h2);
        apb_write(8'h0C, 32'h2);
`endif

        // Random traffic.
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] addrs [7];
            logic [7:0] a;
            logic [31:0] dat;
            addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h1C};
            a = (n % 2 == 0) ? 8'h00 : addrs[$urandom_range(0, 6)];
            dat = $urandom;
            if (a == 8'h08) dat = {31'b0, $urandom_range(0, 7) == 0};
            if (a == 8'h10) dat = {29'b0, 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 2) != 0) apb_write(a, dat);
            else apb_read(a);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
